// File: rtl/ulaaux_seq.sv
// Multicycle shift unit: pass, SLL, SRL, SRA, ROL and ROR of a WIDTH-bit operand,
// shifting STEP positions per clock under a start/done handshake.
module ulaaux_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0]     OP_PASS = 3'b000;
    localparam logic [2:0]     OP_SLL  = 3'b001;
    localparam logic [2:0]     OP_SRL  = 3'b010;
    localparam logic [2:0]     OP_SRA  = 3'b011;
    localparam logic [2:0]     OP_ROL  = 3'b100;
    localparam logic [2:0]     OP_ROR  = 3'b101;
    localparam logic [SHW-1:0] STEP_W  = SHW'(STEP);
    localparam logic [SHW:0]   WIDTH_W = (SHW+1)'(WIDTH);

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   rem_r;
    logic [2:0]       op_r;
    logic             sign_r;
    logic             busy_r;
    logic             done_r;
    logic             illegal_r;
    logic [WIDTH-1:0] result_r;
    logic [SHW-1:0]   k_s;
    logic [WIDTH-1:0] shifted_s;
    logic             ctrl_ill_s;
    logic             zero_len_s;

    // One partial shift of k positions; SRA fills from the sign captured at start.
    function automatic logic [WIDTH-1:0] shift_step(input logic [2:0]       op,
                                                    input logic [WIDTH-1:0] val,
                                                    input logic             sign,
                                                    input logic [SHW-1:0]   k);
        logic [WIDTH-1:0] fill_mask;
        logic [SHW:0]     rk;
        fill_mask = ~({WIDTH{1'b1}} >> k);
        rk        = WIDTH_W - {1'b0, k};
        case (op)
            OP_SLL:  shift_step = val << k;
            OP_SRL:  shift_step = val >> k;
            OP_SRA:  shift_step = (val >> k) | (sign ? fill_mask : {WIDTH{1'b0}});
            OP_ROL:  shift_step = (val << k) | (val >> rk);
            OP_ROR:  shift_step = (val >> k) | (val << rk);
            default: shift_step = val;
        endcase
    endfunction

    assign ctrl_ill_s = ctrl[2] & ctrl[1];
    assign zero_len_s = (ctrl == OP_PASS) || ctrl_ill_s || (shamt == {SHW{1'b0}});
    assign k_s        = (rem_r < STEP_W) ? rem_r : STEP_W;
    assign shifted_s  = shift_step(op_r, work_r, sign_r, k_s);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; zero-length operations skip SHIFT entirely.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = zero_len_s ? ST_DONE : ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (rem_r <= STEP_W) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs; result only changes on DONE entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_r    <= {WIDTH{1'b0}};
            rem_r     <= {SHW{1'b0}};
            op_r      <= 3'b000;
            sign_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            result_r  <= {WIDTH{1'b0}};
        end else begin
            busy_r    <= (state_nx_s != ST_IDLE);
            done_r    <= (state_nx_s == ST_DONE);
            illegal_r <= (state_r == ST_IDLE) && start && ctrl_ill_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        work_r <= a;
                        rem_r  <= shamt;
                        op_r   <= ctrl;
                        sign_r <= a[WIDTH-1];
                        if (zero_len_s) begin
                            result_r <= a;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_r <= shifted_s;
                    rem_r  <= rem_r - k_s;
                    if (state_nx_s == ST_DONE) begin
                        result_r <= shifted_s;
                    end
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign illegal = illegal_r;
    assign result  = result_r;

endmodule

// File: tb/tb_ulaaux_seq.sv
// Directed bench for ulaaux_seq: one instance with STEP=1 and one with STEP=4.
module tb_ulaaux_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start4;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy1, done1, ill1;
    logic [31:0] res1;
    logic        busy4, done4, ill4;
    logic [31:0] res4;
    int          ncmp  = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    ulaaux_seq #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ctrl(ctrl), .a(a), .shamt(shamt),
        .busy(busy1), .done(done1), .illegal(ill1), .result(res1)
    );

    ulaaux_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .ctrl(ctrl), .a(a), .shamt(shamt),
        .busy(busy4), .done(done4), .illegal(ill4), .result(res4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Launch one operation; exp_lat is the number of edges after the sampling edge
    // until done is seen (zero-length operations enter DONE on the sampling edge).
    task automatic run_op(input bit sel, input logic [2:0] c, input logic [31:0] av,
                          input logic [4:0] sh, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_lat, input string tag);
        int          cnt;
        int          bcnt;
        logic [31:0] prev;
        @(negedge clk);
        ctrl  = c;
        a     = av;
        shamt = sh;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        prev = sel ? res4 : res1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        a      = 32'h0;
        cnt    = 0;
        bcnt   = 0;
        while (!(sel ? done4 : done1) && cnt < 200) begin
            chk({tag, ".busy"}, {31'd0, sel ? busy4 : busy1}, 32'd1);
            chk({tag, ".hold"}, sel ? res4 : res1, prev);
            bcnt++;
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, ".done"},    {31'd0, sel ? done4 : done1}, 32'd1);
        chk({tag, ".latency"}, cnt, exp_lat);
        chk({tag, ".result"},  sel ? res4 : res1, exp_res);
        chk({tag, ".illegal"}, {31'd0, sel ? ill4 : ill1}, {31'd0, exp_ill});
        chk({tag, ".busydone"}, {31'd0, sel ? busy4 : busy1}, 32'd1);
        if (exp_lat > 0) chk({tag, ".busycycles"}, bcnt, exp_lat);
        @(posedge clk); #1;
        chk({tag, ".idle_busy"}, {31'd0, sel ? busy4 : busy1}, 32'd0);
        chk({tag, ".idle_done"}, {31'd0, sel ? done4 : done1}, 32'd0);
        chk({tag, ".idle_ill"},  {31'd0, sel ? ill4 : ill1}, 32'd0);
        chk({tag, ".idle_res"},  sel ? res4 : res1, exp_res);
    endtask

    initial begin
        int cnt;
        reset  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        ctrl   = 3'b000;
        a      = 32'h0;
        shamt  = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy1}, 32'd0);
        chk("rst.done", {31'd0, done1}, 32'd0);
        chk("rst.ill",  {31'd0, ill1},  32'd0);
        chk("rst.res",  res1, 32'h0);
        chk("rst.res4", res4, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 3'b011, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 31, "sra31");
        run_op(1'b0, 3'b001, 32'h00000001, 5'd4,  32'h00000010, 1'b0, 4,  "sll4");
        run_op(1'b1, 3'b001, 32'h00000001, 5'd4,  32'h00000010, 1'b0, 1,  "sll4_s4");
        run_op(1'b1, 3'b011, 32'h80000000, 5'd6,  32'hFE000000, 1'b0, 2,  "sra6_s4");
        run_op(1'b1, 3'b101, 32'h0000000F, 5'd5,  32'h78000000, 1'b0, 2,  "ror5_s4");
        run_op(1'b0, 3'b101, 32'h00000001, 5'd1,  32'h80000000, 1'b0, 1,  "ror1");
        run_op(1'b0, 3'b100, 32'h80000001, 5'd4,  32'h00000018, 1'b0, 4,  "rol4");
        run_op(1'b0, 3'b010, 32'hF0000000, 5'd28, 32'h0000000F, 1'b0, 28, "srl28");
        run_op(1'b0, 3'b001, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 31, "sll31");
        run_op(1'b0, 3'b011, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 0,  "sra0");
        run_op(1'b0, 3'b111, 32'hDEADBEEF, 5'd9,  32'hDEADBEEF, 1'b1, 0,  "ill111");
        run_op(1'b0, 3'b110, 32'h0BADF00D, 5'd3,  32'h0BADF00D, 1'b1, 0,  "ill110");
        run_op(1'b0, 3'b000, 32'h13572468, 5'd5,  32'h13572468, 1'b0, 0,  "pass5");

        // start pulses mid-SHIFT and in the DONE cycle must both be ignored
        @(negedge clk);
        ctrl   = 3'b001;
        a      = 32'h00000001;
        shamt  = 5'd20;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cnt    = 0;
        while (!done1 && cnt < 200) begin
            if (cnt == 8) begin
                start1 = 1'b1;
                ctrl   = 3'b000;
                a      = 32'hFFFFFFFF;
                shamt  = 5'd3;
            end else begin
                start1 = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        chk("ign.done",    {31'd0, done1}, 32'd1);
        chk("ign.latency", cnt, 20);
        chk("ign.result",  res1, 32'h00100000);
        start1 = 1'b1;
        ctrl   = 3'b000;
        a      = 32'h12345678;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("ign.busy1", {31'd0, busy1}, 32'd0);
        chk("ign.done1", {31'd0, done1}, 32'd0);
        chk("ign.res1",  res1, 32'h00100000);
        @(posedge clk); #1;
        chk("ign.busy2", {31'd0, busy1}, 32'd0);
        chk("ign.done2", {31'd0, done1}, 32'd0);

        // asynchronous reset in the middle of a shift aborts it
        @(negedge clk);
        ctrl   = 3'b010;
        a      = 32'hFFFF0000;
        shamt  = 5'd16;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort.busy_pre", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort.busy", {31'd0, busy1}, 32'd0);
        chk("abort.done", {31'd0, done1}, 32'd0);
        chk("abort.res",  res1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort.nodone", {31'd0, done1}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b0, 3'b000, 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5, 1'b0, 0, "pass_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
